ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch unit and instruction queue feeding `decode`. It generates sequential word fetches (next PC = PC + 4) to the memory controller and buffers returned instructions with their PCs in a small FIFO. It presents the FIFO head to `decode` through `decode_flag`/`ins`/`ins_pc` and dequeues when decode accepts. A ROB-initiated `clear` flushes the FIFO and redirects fetch.

## Interface
- `QUEUE_DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0: first fetch address after reset.

- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `rdy_in`  input  1  global ready; when 0, all state holds.
- `mem_req`  output  1  fetch request valid (registered).
- `mem_addr`  output  32  word address of the request (registered, `[1:0]` = 0).
- `mem_done`  input  1  one-cycle pulse; `mem_data` valid this cycle.
- `mem_data`  input  32  fetched instruction.
- `decode_flag`  output  1  FIFO head valid.
- `ins`  output  32  head instruction.
- `ins_pc`  output  32  head PC.
- `decode_ok`  input  1  decode accepted the head this cycle.
- `clear`  input  1  flush and redirect (ROB mispredict/jump).
- `clear_pc`  input  32  redirect target; bits `[1:0]` are forced to 0.

## Operation
- State: `fetch_pc`, FIFO (`head`, `tail`, `count` of width log2(QUEUE_DEPTH)+1), and an FSM with states IDLE, WAIT, DISCARD.
- IDLE:
  - If `count < QUEUE_DEPTH`, assert `mem_req`, set `mem_addr = fetch_pc`, and go to WAIT.
  - Otherwise stay in IDLE with `mem_req = 0`.
- WAIT:
  - `mem_req` and `mem_addr` are held stable.
  - On `mem_done`, write {`mem_data`, `mem_addr`} at `tail`, advance `tail` with wrap, set `fetch_pc += 4` (32-bit wrap), deassert `mem_req`, and go to IDLE.
- DISCARD (the stale request was in flight when `clear` arrived):
  - `mem_req` and the stale `mem_addr` are held until `mem_done`.
  - On `mem_done`, drop the data, deassert `mem_req`, and go to IDLE. `fetch_pc` is not incremented.
- At most one outstanding request at any time.
- Head output:
  - `decode_flag = (count != 0)`.
  - `ins`/`ins_pc` are driven from the entry at `head`; their values are only meaningful while `decode_flag = 1`.
- Dequeue: `decode_ok && decode_flag` advances `head` with wrap. `decode_ok` while empty is ignored.
- Simultaneous enqueue and dequeue: `count` is unchanged. Enqueue into a full FIFO cannot happen, because a request is only issued when `count < QUEUE_DEPTH` and that slot stays reserved.
- `clear`, which has priority over every other event in the same cycle:
  - Set `count`, `head`, `tail` to 0 and `fetch_pc` to `{clear_pc[31:2],2'b00}`.
  - From WAIT without `mem_done` in the same cycle: go to DISCARD.
  - From WAIT with `mem_done` in the same cycle: data is dropped; go to IDLE.
  - From IDLE or DISCARD: stay in the same state, with DISCARD still waiting for its `mem_done`.
  - A `decode_ok` in the same cycle is ignored.
- `rdy_in = 0` freezes everything. `mem_done` is not pulsed while `rdy_in = 0`; if it is, it is ignored.

## Timing
- Reset values (asynchronous, while `rst_in = 0`):
  - `mem_req` = 0, `mem_addr` = RESET_PC.
  - `fetch_pc` = RESET_PC, `count`/`head`/`tail` = 0, state IDLE.
  - All FIFO entries = 0, so `decode_flag` = 0, `ins` = 0, `ins_pc` = 0.
- First `mem_req = 1` is visible after the first rising edge following reset release.
- `mem_done` at edge t causes `decode_flag = 1` after edge t, so the entry is available to decode in cycle t+1.
- After `mem_done`, `mem_req` is low for exactly one cycle (IDLE) before the next request. Sustained throughput is one instruction per (memory latency + 1) cycles.
- `clear` at edge t: `decode_flag = 0` after edge t. The next request from `clear_pc` is issued at edge t+1 from IDLE, or one cycle after the stale `mem_done` from DISCARD.
- A reset asserted mid-request aborts immediately. The memory controller is reset by the same `rst_in`.

## Test plan
- Reset release, memory latency 3, decode always accepts: `mem_addr` sequence is 0, 4, 8, …. Each `ins`/`ins_pc` pair matches memory, with `ins_pc` = 0, 4, 8. `decode_flag` first rises one cycle after the first `mem_done`.
- Decode stalled (`decode_ok = 0`), QUEUE_DEPTH = 4: exactly four requests (0x0–0xC) complete, then `mem_req` stays 0 and `count` = 4. Releasing decode drains the entries in order 0x0, 0x4, 0x8, 0xC, and fetch resumes at 0x10.
- Full FIFO, `decode_ok` pulsed once: one dequeue, one new request at 0x10. Enqueue and dequeue landing in the same cycle leave `count` unchanged.
- `clear` with `clear_pc = 0x1002` while in WAIT for 0x8: the 0x8 data is dropped and `decode_flag = 0`. The next request is to 0x1000 after the stale `mem_done`, and the next `ins_pc` is 0x1000.
- `clear` coincident with `mem_done` and `decode_ok`: nothing is enqueued or dequeued, `count` = 0, and the next request is to `clear_pc` one cycle later.
- `rdy_in = 0` for 5 cycles mid-WAIT: outputs and `count` are frozen. Normal sequencing continues afterwards.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small instruction FIFO in front of decode.
// Issues sequential word fetches, buffers {instruction, pc} pairs and flushes/redirects on clear.
module ifetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        decode_flag,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        decode_ok,
  input  logic        clear,
  input  logic [31:0] clear_pc
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t           state, state_next;
  logic [31:0]      fetch_pc, pc_next;
  logic [31:0]      addr_next;
  logic             req_next;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             enq, deq, flush;

  logic [31:0] ins_q [QUEUE_DEPTH];
  logic [31:0] pc_q  [QUEUE_DEPTH];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Clear wins over every other event; an in-flight request must still be
  // drained, so WAIT without a same-cycle completion moves to DISCARD.
  always_comb begin
    state_next = state;
    req_next   = mem_req;
    addr_next  = mem_addr;
    pc_next    = fetch_pc;
    enq        = 1'b0;
    deq        = 1'b0;
    flush      = 1'b0;
    if (rdy_in) begin
      if (clear) begin
        flush   = 1'b1;
        pc_next = clear_pc & ~32'h3;
        case (state)
          WAIT: begin
            if (mem_done) begin
              state_next = IDLE;
              req_next   = 1'b0;
            end else begin
              state_next = DISCARD;
            end
          end
          DISCARD: begin
            if (mem_done) begin
              state_next = IDLE;
              req_next   = 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        deq = decode_ok && (count != '0);
        case (state)
          IDLE: begin
            if (count < DEPTH_CNT) begin
              req_next   = 1'b1;
              addr_next  = fetch_pc;
              state_next = WAIT;
            end
          end
          WAIT: begin
            if (mem_done) begin
              enq        = 1'b1;
              pc_next    = fetch_pc + 32'd4;
              req_next   = 1'b0;
              state_next = IDLE;
            end
          end
          DISCARD: begin
            if (mem_done) begin
              req_next   = 1'b0;
              state_next = IDLE;
            end
          end
          default: begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      mem_req  <= req_next;
      mem_addr <= addr_next;
      fetch_pc <= pc_next;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) tail <= tail + PTR_W'(1);
        if (deq) head <= head + PTR_W'(1);
        if (enq && !deq) begin
          count <= count + CNT_W'(1);
        end else if (deq && !enq) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (enq) begin
      ins_q[tail] <= mem_data;
      pc_q[tail]  <= mem_addr;
    end
  end

  assign decode_flag = (count != '0);
  assign ins         = ins_q[head];
  assign ins_pc      = pc_q[head];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue; the bench plays a fixed
// 3-cycle-latency memory that returns addr ^ 32'hC0DE0000.
module tb_ifetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;
  logic        decode_flag;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        decode_ok = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] clear_pc = '0;

  int n_cmp = 0;
  int n_err = 0;
  int mcnt  = 0;
  int pulses = 0;
  int n;

  localparam int LAT = 3;

  ifetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data),
    .decode_flag(decode_flag), .ins(ins), .ins_pc(ins_pc),
    .decode_ok(decode_ok), .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, then advance the memory model.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (!rst_in) begin
      mcnt = 0;
      mem_done = 1'b0;
    end else if (mem_done) begin
      mem_done = 1'b0;
      mcnt = 0;
    end else if (rdy_in && mem_req) begin
      mcnt++;
      if (mcnt == LAT) begin
        mem_done = 1'b1;
        mem_data = mem_word(mem_addr);
        pulses++;
      end
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    decode_ok = 1'b0;
    clear = 1'b0;
    rdy_in = 1'b1;
    mem_done = 1'b0;
    mcnt = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_flag", {31'b0, decode_flag}, 32'd0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h0);
    do_reset();

    // Streaming with decode always accepting
    decode_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin tick(); n++; end while (!mem_req && n < 20);
      chk("seq_req", {31'b0, mem_req}, 32'd1);
      chk("seq_addr", mem_addr, 32'(4 * k));
      n = 0;
      do begin tick(); n++; end while (!decode_flag && n < 20);
      if (k == 0) chk("first_flag_lat", 32'(n), 32'd3);
      chk("seq_flag", {31'b0, decode_flag}, 32'd1);
      chk("seq_ins_pc", ins_pc, 32'(4 * k));
      chk("seq_ins", ins, mem_word(32'(4 * k)));
    end

    // Reset mid-request aborts asynchronously
    tick();
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    rst_in = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_addr", mem_addr, 32'h0);
    do_reset();

    // Decode stalled: fills to four entries then stops requesting
    pulses = 0;
    repeat (30) tick();
    chk("stall_pulses", 32'(pulses), 32'd4);
    chk("stall_req", {31'b0, mem_req}, 32'd0);
    chk("stall_flag", {31'b0, decode_flag}, 32'd1);
    chk("stall_head", ins_pc, 32'h0);

    // Single dequeue from full, then refetch at 0x10
    decode_ok = 1'b1;
    tick();
    decode_ok = 1'b0;
    chk("deq1_head", ins_pc, 32'h4);
    chk("deq1_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("refill_req", {31'b0, mem_req}, 32'd1);
    chk("refill_addr", mem_addr, 32'h10);
    n = 0;
    do begin tick(); n++; end while (!mem_done && n < 20);
    chk("refill_done", {31'b0, mem_done}, 32'd1);
    // Enqueue and dequeue on the same edge, then drain to confirm 3 entries
    decode_ok = 1'b1;
    tick();
    chk("both_flag", {31'b0, decode_flag}, 32'd1);
    chk("drain0", ins_pc, 32'h8);
    tick();
    chk("drain1", ins_pc, 32'hC);
    tick();
    chk("drain2", ins_pc, 32'h10);
    chk("drain2_ins", ins, mem_word(32'h10));
    tick();
    chk("drained_flag", {31'b0, decode_flag}, 32'd0);
    n = 0;
    do begin tick(); n++; end while (!decode_flag && n < 20);
    chk("resume_pc", ins_pc, 32'h14);
    do_reset();

    // Clear while waiting for 0x8
    n = 0;
    do begin tick(); n++; end while (!(mem_req && mem_addr == 32'h8) && n < 30);
    chk("wait8_addr", mem_addr, 32'h8);
    clear = 1'b1;
    clear_pc = 32'h1002;
    tick();
    clear = 1'b0;
    chk("clr_flag", {31'b0, decode_flag}, 32'd0);
    chk("discard_req", {31'b0, mem_req}, 32'd1);
    chk("discard_addr", mem_addr, 32'h8);
    n = 0;
    do begin tick(); n++; end while (mem_req && n < 20);
    chk("stale_dropped_req", {31'b0, mem_req}, 32'd0);
    chk("stale_dropped_flag", {31'b0, decode_flag}, 32'd0);
    tick();
    chk("redir_req", {31'b0, mem_req}, 32'd1);
    chk("redir_addr", mem_addr, 32'h1000);
    n = 0;
    do begin tick(); n++; end while (!decode_flag && n < 20);
    chk("redir_ins_pc", ins_pc, 32'h1000);
    chk("redir_ins", ins, mem_word(32'h1000));

    // Clear coincident with mem_done and decode_ok
    n = 0;
    do begin tick(); n++; end while (!mem_done && n < 20);
    chk("co_done", {31'b0, mem_done}, 32'd1);
    clear = 1'b1;
    clear_pc = 32'h2000;
    decode_ok = 1'b1;
    tick();
    clear = 1'b0;
    decode_ok = 1'b0;
    chk("co_flag", {31'b0, decode_flag}, 32'd0);
    chk("co_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("co_next_req", {31'b0, mem_req}, 32'd1);
    chk("co_next_addr", mem_addr, 32'h2000);

    // rdy_in low mid-WAIT freezes everything
    rdy_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("frz_req", {31'b0, mem_req}, 32'd1);
      chk("frz_addr", mem_addr, 32'h2000);
    end
    chk("frz_flag", {31'b0, decode_flag}, 32'd0);
    rdy_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!decode_flag && n < 20);
    chk("thaw_ins_pc", ins_pc, 32'h2000);
    chk("thaw_ins", ins, mem_word(32'h2000));
    n = 0;
    do begin tick(); n++; end while (!mem_req && n < 20);
    chk("thaw_next_addr", mem_addr, 32'h2004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
